mem_latency_model: RTL and testbench
====================================

Name: mem_latency_model

Overview:
- Word-addressed main-memory block directly downstream of the cache controller.
- Consumes the controller's single-outstanding req/we/addr/wdata request stream.
- Answers each request after a fixed, parameterised latency with a one-cycle done pulse, plus rdata for reads.
- Drives ready so the controller can issue back-to-back refill beats and write-through stores.
- Keeps saturating read/write access counters for performance measurement.

Parameters:
- ADDR_W, 16, request address width; the address is a word address.
- DATA_W, 32, data word width.
- MEM_AW, 12, implemented array depth is 2^MEM_AW words; addr[MEM_AW-1:0] indexes the array.
- LATENCY, 4, cycles from request acceptance to done; legal range 1..15.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only when ready=1.
- we  in  1  1=write, 0=read; qualified by req.
- addr  in  ADDR_W  word address; qualified by req.
- wdata  in  DATA_W  write data; qualified by req&we.
- ready  out  1  block can accept a request this cycle.
- done  out  1  one-cycle pulse, request completed.
- rdata  out  DATA_W  read data, valid while done=1 for a read.
- busy  out  1  a request is in flight (~ready).
- rd_count  out  CNT_W  accepted reads, saturating.
- wr_count  out  CNT_W  accepted writes, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Values after the rst edge: ready=1, done=0, busy=0, rdata=0, rd_count=0, wr_count=0, FSM=IDLE, latency counter=0.
- Array contents are not cleared by rst. At time zero, word i = i (zero-extended to DATA_W), for deterministic benches.
- Acceptance: a request is accepted at a rising edge where ready=1 and req=1.
  - addr[MEM_AW-1:0], we and wdata are latched on that edge.
  - addr[ADDR_W-1:MEM_AW] is ignored, so addresses alias.
- FSM states:
  - IDLE: ready=1. On acceptance, go to WAIT with the counter loaded to LATENCY-1.
  - WAIT: ready=0. Counter decrements each cycle; when it reaches 0, go to DONE. If LATENCY=1, acceptance goes straight to DONE.
  - DONE: done=1 and ready=1 for exactly one cycle. For a read, rdata = mem[latched addr]. For a write, mem[latched addr] <= latched wdata at the edge ending DONE.
    - A new request accepted in DONE loads the counter and goes to WAIT (or DONE if LATENCY=1). This allows back-to-back beats.
    - With no new request, go to IDLE.
- Latency: a request accepted at edge t produces done high in the cycle after edge t+LATENCY-1, i.e. done is seen at edge t+LATENCY.
- Sustained back-to-back throughput: one request per LATENCY cycles.
- rdata holds its last read value outside DONE. A write's DONE does not change rdata.
- Read in DONE of a write (same-cycle hazard):
  - A read accepted in the DONE cycle of a write to the same address, with LATENCY=1, must return the new write data (forwarding).
  - With LATENCY>1 the write has committed before the read is sampled. The array is read in the DONE cycle, never at acceptance.
- req in WAIT is ignored: no latch, no count, no error. The controller may hold req high while ready=0.
- Counters:
  - rd_count increments on each accepted read; wr_count on each accepted write.
  - Both hold at 2^CNT_W-1 and never wrap.
- Reset mid-operation: an in-flight request is abandoned. No done pulse, a pending write is not committed, counters clear.
- ready is a registered function of state only; it has no combinational path from req.

Test Plan:
- Reset, LATENCY=4: after rst, ready=1 and done=0; read addr 0x0010 accepted at edge t -> done=1 and rdata=0x00000010 at edge t+4; ready=0 for edges t+1..t+3.
- Write then read: write addr 0x0020 data 0xDEADBEEF, wait done, read 0x0020 -> rdata=0xDEADBEEF; wr_count=1, rd_count=1.
- Eight-beat refill: read 0x0A00..0x0A07, each issued in the DONE cycle of the previous one -> 8 done pulses spaced 4 cycles apart, rdata=0x0A00..0x0A07 in order, total 32 cycles, rd_count=8.
- Busy ignore: hold req=1 with addr 0x0055 throughout WAIT of a read to 0x0011 -> only 0x0011 completes, then 0x0055 is accepted in the DONE cycle; rd_count=2.
- Aliasing and LATENCY=1 forwarding: write 0xF123 data 0x1, then read 0x0123 accepted in that write's DONE cycle -> done next cycle, rdata=0x00000001.
- Reset mid-op: write 0x0030 data 0xAAAA5555, assert rst two cycles after accept -> no done pulse; a later read of 0x0030 returns 0x00000030; counters read 0 after reset.

Source files
------------

// File: rtl/mem_latency_model.sv
// Word-addressed main memory behind the cache controller: answers each accepted
// request after LATENCY cycles with a one-cycle done pulse, and counts reads/writes.
module mem_latency_model #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int         DEPTH    = 1 << MEM_AW;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [MEM_AW-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_rd_count;
  logic [CNT_W-1:0]  r_wr_count;

  // Untouched words read back as their own index, so the array itself never
  // needs clearing; r_written marks the words that hold stored data.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_written = '0;
  logic [DATA_W-1:0] r_mem_q;
  logic [DATA_W-1:0] r_alt_q;
  logic              r_use_mem;

  logic              w_ready;
  logic              w_accept;
  logic              w_commit;
  logic              w_load_rdata;
  logic              w_fwd;
  logic              w_rd_we;
  logic [MEM_AW-1:0] w_rd_addr;
  logic              w_unused;

  assign w_ready  = (r_state != S_WAIT);
  assign w_accept = req && w_ready;
  assign w_commit = (r_state == S_DONE) && r_we;

  // The operation entering DONE is either the one just accepted (LATENCY=1)
  // or the one already latched and finishing its wait.
  assign w_rd_addr    = w_accept ? addr[MEM_AW-1:0] : r_addr;
  assign w_rd_we      = w_accept ? we : r_we;
  assign w_load_rdata = (w_state_next == S_DONE) && !w_rd_we;
  assign w_fwd        = w_commit && (r_addr == w_rd_addr);
  assign w_unused     = ^addr[ADDR_W-1:MEM_AW];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (SINGLE) begin
            w_state_next = S_DONE;
            w_cnt_next   = 4'd0;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = CNT_LOAD;
          end
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rd_count <= '0;
      r_wr_count <= '0;
      r_alt_q    <= '0;
      r_use_mem  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= addr[MEM_AW-1:0];
        r_we    <= we;
        r_wdata <= wdata;
        if (we) begin
          if (r_wr_count != {CNT_W{1'b1}}) r_wr_count <= r_wr_count + CNT_W'(1);
        end else begin
          if (r_rd_count != {CNT_W{1'b1}}) r_rd_count <= r_rd_count + CNT_W'(1);
        end
      end
      if (w_load_rdata) begin
        r_alt_q   <= w_fwd ? r_wdata : DATA_W'(w_rd_addr);
        r_use_mem <= !w_fwd && r_written[w_rd_addr];
      end
    end
  end

  // Array port: write at the edge ending a write's DONE, registered read
  // at the edge entering a read's DONE.
  always_ff @(posedge clk) begin
    if (w_commit && !rst) begin
      r_mem[r_addr] <= r_wdata;
    end
    if (w_load_rdata) begin
      r_mem_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && !rst) begin
      r_written[r_addr] <= 1'b1;
    end
  end

  assign ready    = w_ready;
  assign busy     = !w_ready;
  assign done     = (r_state == S_DONE);
  assign rdata    = r_use_mem ? r_mem_q : r_alt_q;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_mem_latency_model.sv
// Bench for mem_latency_model: a LATENCY=4 and a LATENCY=1 instance, each checked
// every cycle against a timestamp-based transaction model plus directed literals.
module tb_mem_latency_model;

  logic        clk;
  logic        a_rst, a_req, a_we;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ready, a_done, a_busy;
  logic [31:0] a_rdata;
  logic [15:0] a_rd, a_wr;

  logic        b_rst, b_req, b_we;
  logic [15:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ready, b_done, b_busy;
  logic [31:0] b_rdata;
  logic [15:0] b_rd, b_wr;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  mem_latency_model #(.LATENCY(4)) u_a (
    .clk(clk), .rst(a_rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .ready(a_ready), .done(a_done), .rdata(a_rdata), .busy(a_busy),
    .rd_count(a_rd), .wr_count(a_wr)
  );

  mem_latency_model #(.LATENCY(1)) u_b (
    .clk(clk), .rst(b_rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .ready(b_ready), .done(b_done), .rdata(b_rdata), .busy(b_busy),
    .rd_count(b_rd), .wr_count(b_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // Transaction model: a request accepted at edge e completes in the cycle after
  // edge e+L-1; acceptance is possible when nothing is in flight or in that cycle.
  logic        m_infl  [2];
  logic [11:0] m_addr  [2];
  logic        m_we    [2];
  logic [31:0] m_wd    [2];
  int          m_dedge [2];
  logic [15:0] m_rdc   [2];
  logic [15:0] m_wrc   [2];
  logic [31:0] m_rd    [2];
  logic        m_edone [2];
  logic        m_eready[2];
  logic        m_armed [2];
  logic [31:0] m_mem   [2][4096];

  task automatic step(input int k, input int lat, input logic rst, input logic req,
                      input logic we, input logic [15:0] ad, input logic [31:0] wd);
    logic can_accept;
    if (rst) begin
      m_infl[k]  = 1'b0;
      m_rdc[k]   = 16'h0;
      m_wrc[k]   = 16'h0;
      m_rd[k]    = 32'h0;
      m_armed[k] = 1'b1;
    end else begin
      can_accept = !m_infl[k] || (m_dedge[k] == edge_n - 1);
      if (m_infl[k] && (m_dedge[k] == edge_n - 1)) begin
        if (m_we[k]) m_mem[k][m_addr[k]] = m_wd[k];
        m_infl[k] = 1'b0;
      end
      if (can_accept && req) begin
        m_infl[k]  = 1'b1;
        m_addr[k]  = ad[11:0];
        m_we[k]    = we;
        m_wd[k]    = wd;
        m_dedge[k] = edge_n + lat - 1;
        if (we) begin
          if (m_wrc[k] != 16'hFFFF) m_wrc[k] = m_wrc[k] + 16'h1;
        end else begin
          if (m_rdc[k] != 16'hFFFF) m_rdc[k] = m_rdc[k] + 16'h1;
        end
      end
    end
    m_edone[k]  = m_infl[k] && (m_dedge[k] == edge_n);
    m_eready[k] = !m_infl[k] || m_edone[k];
    if (m_edone[k] && !m_we[k]) m_rd[k] = m_mem[k][m_addr[k]];
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_infl[k] = 1'b0; m_armed[k] = 1'b0; m_dedge[k] = -10;
      m_rdc[k] = 16'h0; m_wrc[k] = 16'h0; m_rd[k] = 32'h0; m_we[k] = 1'b0;
      m_addr[k] = 12'h0; m_wd[k] = 32'h0; m_edone[k] = 1'b0; m_eready[k] = 1'b1;
      for (int i = 0; i < 4096; i++) m_mem[k][i] = i;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      step(0, 4, a_rst, a_req, a_we, a_addr, a_wdata);
      step(1, 1, b_rst, b_req, b_we, b_addr, b_wdata);
      @(negedge clk);
      if (m_armed[0]) begin
        chk("A.ready", a_ready, m_eready[0]);
        chk("A.busy", a_busy, !m_eready[0]);
        chk("A.done", a_done, m_edone[0]);
        chk("A.rdata", a_rdata, m_rd[0]);
        chk("A.rd_count", a_rd, m_rdc[0]);
        chk("A.wr_count", a_wr, m_wrc[0]);
      end
      if (m_armed[1]) begin
        chk("B.ready", b_ready, m_eready[1]);
        chk("B.busy", b_busy, !m_eready[1]);
        chk("B.done", b_done, m_edone[1]);
        chk("B.rdata", b_rdata, m_rd[1]);
        chk("B.rd_count", b_rd, m_rdc[1]);
        chk("B.wr_count", b_wr, m_wrc[1]);
      end
    end
  end

  // Drivers: called at a negedge, return at a negedge.
  task automatic a_reset();
    a_rst = 1'b1; a_req = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
  endtask

  task automatic a_send(input logic we, input logic [15:0] ad, input logic [31:0] wd);
    int n;
    n = 0;
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    while (!a_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      n_tests++; n_fail++;
      $display("FAIL A.accept_timeout: got ready=0, expected ready=1 within 40 cycles");
    end
    $display("[TB] A issue %s addr=%h wdata=%h", we ? "WR" : "RD", ad, wd);
  endtask

  task automatic a_wait(input bit drop, output int c, output int nr);
    c = 0; nr = 0;
    do begin
      @(negedge clk);
      c++;
      if (drop && c == 1) a_req = 1'b0;
      if (!a_ready) nr++;
    end while (!a_done && c < 40);
    if (!a_done) begin
      n_tests++; n_fail++;
      $display("FAIL A.done_timeout: got done=0, expected done=1 within 40 cycles");
    end
    $display("[TB] A done rdata=%h after %0d cycles", a_rdata, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nr, tot, seen;
    a_rst = 1'b1; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Reset state and basic read latency
    chk("t1.ready", a_ready, 1);
    chk("t1.done", a_done, 0);
    chk("t1.rdata", a_rdata, 32'h0);
    a_send(1'b0, 16'h0010, 32'h0);
    a_wait(1'b1, c, nr);
    chk("t1.latency", c, 4);
    chk("t1.notready", nr, 3);
    chk("t1.rdata_done", a_rdata, 32'h0000_0010);

    // Write then read back, including an aliased read and an untouched word
    a_reset();
    a_send(1'b1, 16'h0020, 32'hDEAD_BEEF);
    a_wait(1'b1, c, nr);
    chk("t2.wr_latency", c, 4);
    a_send(1'b0, 16'h0020, 32'h0);
    a_wait(1'b1, c, nr);
    chk("t2.rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t2.wr_count", a_wr, 1);
    chk("t2.rd_count", a_rd, 1);
    a_send(1'b0, 16'h1020, 32'h0);
    a_wait(1'b1, c, nr);
    chk("t2.alias", a_rdata, 32'hDEAD_BEEF);
    a_send(1'b0, 16'h0FFF, 32'h0);
    a_wait(1'b1, c, nr);
    chk("t2.init_word", a_rdata, 32'h0000_0FFF);

    // Eight-beat refill, each beat issued in the previous beat's DONE cycle
    a_reset();
    a_send(1'b0, 16'h0A00, 32'h0);
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      a_wait(1'b0, c, nr);
      tot += c;
      chk("t3.gap", c, 4);
      chk("t3.rdata", a_rdata, 32'h0000_0A00 + i);
      if (i < 7) a_addr = 16'h0A01 + 16'(i);
      else a_req = 1'b0;
    end
    chk("t3.total", tot, 32);
    @(negedge clk);
    chk("t3.rd_count", a_rd, 8);

    // req held high through WAIT is ignored
    a_reset();
    a_send(1'b0, 16'h0011, 32'h0);
    @(negedge clk);
    a_addr = 16'h0055;
    a_wait(1'b0, c, nr);
    chk("t4.first_gap", c, 3);
    chk("t4.first_rdata", a_rdata, 32'h0000_0011);
    chk("t4.rd_count_mid", a_rd, 1);
    a_wait(1'b1, c, nr);
    chk("t4.second_gap", c, 4);
    chk("t4.second_rdata", a_rdata, 32'h0000_0055);
    chk("t4.rd_count", a_rd, 2);

    // LATENCY=1: aliased write, then forwarded read accepted in the write's DONE
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'hF123; b_wdata = 32'h0000_0001;
    @(negedge clk);
    chk("t5.wr_done", b_done, 1);
    b_we = 1'b0; b_addr = 16'h0123;
    @(negedge clk);
    chk("t5.rd_done", b_done, 1);
    chk("t5.fwd_rdata", b_rdata, 32'h0000_0001);
    chk("t5.wr_count", b_wr, 1);
    chk("t5.rd_count", b_rd, 1);
    $display("[TB] B forwarded read addr=0123 rdata=%h", b_rdata);
    b_addr = 16'h2123;
    @(negedge clk);
    chk("t5.stored_rdata", b_rdata, 32'h0000_0001);
    b_addr = 16'h0456;
    @(negedge clk);
    chk("t5.init_rdata", b_rdata, 32'h0000_0456);
    b_req = 1'b0;
    @(negedge clk);
    chk("t5.idle_done", b_done, 0);

    // Reset two cycles after a write is accepted abandons it
    a_reset();
    a_send(1'b1, 16'h0030, 32'hAAAA_5555);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_done) seen++;
    end
    chk("t6.no_done", seen, 0);
    chk("t6.rd_count", a_rd, 0);
    chk("t6.wr_count", a_wr, 0);
    a_send(1'b0, 16'h0030, 32'h0);
    a_wait(1'b1, c, nr);
    chk("t6.not_committed", a_rdata, 32'h0000_0030);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
